sha256_req_arbiter: RTL and testbench
=====================================

Name: sha256_req_arbiter

Overview:
Shares one sha256_core between NUM_REQ independent requesters. Each requester submits one pre-padded 512-bit block with a valid/ready handshake. The block grants requesters round-robin, sequences the core's start/digest_valid protocol and returns the 256-bit digest to the granted requester. A watchdog flags a core that never completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 128, max cycles in WAIT before the error response is returned
PTR_W, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request; held until accepted
req_block  input  NUM_REQ*512  per-requester padded block; slice i = [512*i +: 512]
req_ready  output  NUM_REQ  one-hot, one-cycle accept strobe
rsp_valid  output  NUM_REQ  one-hot response valid to the granted requester
rsp_ready  input  NUM_REQ  per-requester response accept
rsp_digest  output  256  digest of the current response
rsp_error  output  1  response produced by timeout; rsp_digest = 0
rsp_id  output  PTR_W  index of the granted requester
core_start  output  1  one-cycle start pulse to sha256_core
core_block  output  512  latched block driven to sha256_core
core_digest  input  256  sha256_core digest
core_digest_valid  input  1  sha256_core done (level or pulse)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready, rsp_valid, core_start, rsp_error = 0; rsp_digest, core_block, counter = 0; rsp_id and rr pointer = 0; dv_q = 0. A reset mid-operation abandons the job with no response.
- dv_q registers core_digest_valid. done = core_digest_valid & ~dv_q (rising edge). This makes the block tolerant of a core that holds digest_valid high.
- IDLE: if |req_valid, the arbiter picks the first set bit searching from ptr upward with wrap, giving index g. In the same cycle: req_ready[g]=1 (combinational, that cycle only), core_block <= req_block[g], rsp_id <= g, next state START. If no request is valid, remain in IDLE.
- START: core_start=1 for exactly one cycle; counter <= 0; next state WAIT.
- WAIT: counter increments each cycle and saturates.
  - On done: rsp_digest <= core_digest, rsp_error <= 0, next state RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_digest <= 0, rsp_error <= 1, next state RESP.
  - done and timeout in the same cycle: done wins.
  - core_digest_valid is ignored in IDLE, START and RESP.
- RESP: rsp_valid[rsp_id]=1. Hold rsp_digest, rsp_error and rsp_id stable until rsp_ready[rsp_id]=1. On that handshake: ptr <= (rsp_id+1) mod NUM_REQ, rsp_valid drops next cycle, next state IDLE. rsp_ready of other requesters is ignored.
- Latency: acceptance in cycle T; core_start in T+1; response appears the cycle after the done edge. No new grant is made in the response-handshake cycle, so there is at most one job in flight.
- Requester rules:
  - req_valid must stay high with a stable block until req_ready.
  - Deasserting req_valid before grant is legal and loses nothing.
  - A requester may re-request while its own response is pending. It is arbitrated only after return to IDLE.
- Fairness: with all NUM_REQ requesting continuously, grants cycle 0,1,...,NUM_REQ-1,0.
- Counter width is $clog2(TIMEOUT_CYCLES+1).
- core_block holds its value from acceptance until the next grant.

Decomposition:
- sha256_pkg holds:
  - SHA_BLOCK_W=512 and SHA_DIGEST_W=256
  - state enum {IDLE, START, WAIT, RESP}
  - test constants ABC_BLOCK and ABC_DIGEST = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad
- One sub-module, rr_arbiter: combinational round-robin pick (req vector, ptr -> grant index, any). It is reusable elsewhere.
- FSM, latches and watchdog stay in sha256_req_arbiter.

Test Plan:
- Single request, real sha256_core: req 1 with ABC_BLOCK -> req_ready[1] for 1 cycle, core_start the next cycle, rsp_valid=0010, rsp_id=1, rsp_digest=ABC_DIGEST, rsp_error=0.
- Simultaneous requests: req_valid=0101 from reset (ptr=0) -> grant 0 first, then 2. Second core_start only after rsp_ready[0]. Both digests correct.
- Fairness: all 4 requesting continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3. No requester is granted twice while another waits.
- Timeout: stub core never asserts digest_valid, TIMEOUT_CYCLES=16 -> response 16 cycles after entering WAIT with rsp_error=1, rsp_digest=0. The next request is then served normally.
- Level-held done and backpressure: stub holds digest_valid high across jobs and rsp_ready is held low for 10 cycles. Response stays stable for all 10 cycles; the second job completes only on a fresh rising edge.
- Reset mid-WAIT: assert rst_n=0 asynchronously during WAIT. All outputs go to 0 immediately with no response. After release, a new request to requester 3 is granted first, with ptr=0 searching to 3.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 request arbiter slice.
//   SHA_BLOCK_W / SHA_DIGEST_W : block and digest widths of sha256_core
//   state_e                    : arbiter sequencing states
//   ABC_BLOCK / ABC_DIGEST     : padded "abc" block and its SHA-256 digest
package sha256_pkg;

  localparam int unsigned SHA_BLOCK_W  = 512;
  localparam int unsigned SHA_DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

  // "abc" (0x616263) followed by the 0x80 pad byte and the 24-bit length.
  localparam logic [SHA_BLOCK_W-1:0] ABC_BLOCK =
    {32'h61626380, {14{32'h00000000}}, 32'h00000018};

  localparam logic [SHA_DIGEST_W-1:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : highest-priority index for this pick
//   grant_o : first set request at or after ptr_i, wrapping
//   any_o   : at least one request is set (grant_o is valid)
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] grant_o,
  output logic             any_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/sha256_req_arbiter.sv
// Shares one sha256_core between NUM_REQ requesters.
//   req_valid/req_block/req_ready : per-requester block submission (one-hot accept)
//   rsp_valid/rsp_ready           : per-requester response handshake
//   rsp_digest/rsp_error/rsp_id   : response payload (error = watchdog timeout)
//   core_start/core_block         : job issue to sha256_core
//   core_digest/core_digest_valid : sha256_core result (valid may be level or pulse)
module sha256_req_arbiter
  import sha256_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 128,
  localparam int unsigned PTR_W          = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*SHA_BLOCK_W-1:0] req_block,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [SHA_DIGEST_W-1:0]        rsp_digest,
  output logic                           rsp_error,
  output logic [PTR_W-1:0]               rsp_id,
  output logic                           core_start,
  output logic [SHA_BLOCK_W-1:0]         core_block,
  input  logic [SHA_DIGEST_W-1:0]        core_digest,
  input  logic                           core_digest_valid
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] ID_MAX   = PTR_W'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        rsp_id_q, rsp_id_d;
  logic [SHA_BLOCK_W-1:0]  block_q, block_d;
  logic [SHA_DIGEST_W-1:0] digest_q, digest_d;
  logic                    error_q, error_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dv_q;

  logic [PTR_W-1:0] arb_grant;
  logic             arb_any;
  logic             done;
  logic             timeout;
  logic             rsp_hs;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .grant_o(arb_grant),
    .any_o  (arb_any)
  );

  // Only a rising edge of digest_valid completes a job, so a core that
  // holds the flag high cannot finish the following job early.
  assign done    = core_digest_valid & ~dv_q;
  assign timeout = (cnt_q == CNT_LAST);
  assign rsp_hs  = rsp_ready[rsp_id_q];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (done || timeout) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    unique case (state_q)
      IDLE:    if (arb_any) req_ready[arb_grant] = 1'b1;
      START:   core_start = 1'b1;
      RESP:    rsp_valid[rsp_id_q] = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state: latched block/id, watchdog, response payload, pointer
  always_comb begin
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    block_d  = block_q;
    digest_d = digest_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          block_d  = req_block[32'(arb_grant) * SHA_BLOCK_W +: SHA_BLOCK_W];
          rsp_id_d = arb_grant;
        end
      end
      START: cnt_d = '0;
      WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (done) begin
          digest_d = core_digest;
          error_d  = 1'b0;
        end else if (timeout) begin
          digest_d = '0;
          error_d  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) ptr_d = (rsp_id_q == ID_MAX) ? '0 : rsp_id_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rsp_id_q <= '0;
      block_q  <= '0;
      digest_q <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      dv_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      block_q  <= block_d;
      digest_q <= digest_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      dv_q     <= core_digest_valid;
    end
  end

  assign rsp_digest = digest_q;
  assign rsp_error  = error_q;
  assign rsp_id     = rsp_id_q;
  assign core_block = block_q;

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Self-checking bench for sha256_req_arbiter with a behavioural stub core.
module tb_sha256_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*512-1:0] req_block = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '1;
  logic [255:0]     rsp_digest;
  logic             rsp_error;
  logic [1:0]       rsp_id;
  logic             core_start;
  logic [511:0]     core_block;
  logic [255:0]     core_digest;
  logic             core_digest_valid;

  sha256_req_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_block        (req_block),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_digest       (rsp_digest),
    .rsp_error        (rsp_error),
    .rsp_id           (rsp_id),
    .core_start       (core_start),
    .core_block       (core_block),
    .core_digest      (core_digest),
    .core_digest_valid(core_digest_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] mk_block(input int i, input int n);
    logic [31:0] w;
    w = 32'h13572468 ^ (32'(i) * 32'h01010101) ^ 32'(n);
    return {32'hC0DE0000 | 32'(i * 256 + n), {15{w}}};
  endfunction

  function automatic logic [255:0] ref_digest(input logic [511:0] b);
    if (b == ABC_BLK) return ABC_DIG;
    return b[511:256] ^ b[255:0] ^ {32{8'h5A}};
  endfunction

  // Round-robin choice: rotate so ptr is bit 0, isolate the lowest set bit.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    logic [2*N-1:0] d, low;
    d   = {req, req} >> ptr;
    low = d & (~d + 1'b1);
    return (ptr + $clog2(low)) % N;
  endfunction

  // ---------------- stub core ----------------
  int stub_mode = 0;  // 0 pulse, 1 hold high, 2 never completes
  int stub_lat  = 3;

  initial begin : stub
    int cnt;
    logic [511:0] blk;
    bit re;
    cnt = -1; re = 0; blk = '0;
    core_digest_valid = 1'b0;
    core_digest = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cnt = -1; re = 0; core_digest_valid = 1'b0;
      end else begin
        if (stub_mode == 0 && core_digest_valid) core_digest_valid = 1'b0;
        if (re) begin
          core_digest_valid = 1'b1; core_digest = ref_digest(blk); re = 0;
        end
        if (core_start) begin
          cnt = stub_lat; blk = core_block;
        end else if (cnt > 0) begin
          cnt--;
        end else if (cnt == 0) begin
          cnt = -1;
          if (stub_mode == 0) begin
            core_digest_valid = 1'b1; core_digest = ref_digest(blk);
          end else if (stub_mode == 1) begin
            if (core_digest_valid) begin
              core_digest_valid = 1'b0; re = 1;
            end else begin
              core_digest_valid = 1'b1; core_digest = ref_digest(blk);
            end
          end
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int grant_log[$];

  initial begin : model
    bit job, prev_dv, m_err;
    int t_acc, t_resp, m_id, m_ptr, g;
    logic [511:0] m_blk;
    logic [255:0] m_dig;
    logic [N-1:0] e_rr, e_rv;
    bit e_st;
    job = 0; prev_dv = 0; m_err = 0; t_acc = 0; t_resp = -1;
    m_id = 0; m_ptr = 0; g = 0; m_blk = '0; m_dig = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        job = 0; m_ptr = 0; m_id = 0; m_blk = '0; m_dig = '0; m_err = 0; prev_dv = 0;
        chk("rst_ctl", {req_ready, rsp_valid, core_start, rsp_error, rsp_id}, '0);
        chk("rst_digest", rsp_digest, '0);
        chk("rst_block", core_block, '0);
      end else begin
        e_rr = '0; e_rv = '0;
        e_st = job && (cyc == t_acc + 1);
        if (job && t_resp >= 0 && cyc >= t_resp) e_rv[m_id] = 1'b1;
        if (!job && |req_valid) begin
          g = pick(req_valid, m_ptr);
          e_rr[g] = 1'b1;
        end
        chk("req_ready", req_ready, e_rr);
        chk("core_start", core_start, e_st);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_digest", rsp_digest, m_dig);
        chk("rsp_error", rsp_error, m_err);
        chk("core_block", core_block, m_blk);
        if (job && t_resp < 0) begin
          if (cyc >= t_acc + 2) begin
            if (core_digest_valid && !prev_dv) begin
              t_resp = cyc + 1; m_dig = ref_digest(m_blk); m_err = 0;
            end else if (cyc - (t_acc + 2) == TO - 1) begin
              t_resp = cyc + 1; m_dig = '0; m_err = 1;
            end
          end
        end else if (job && cyc >= t_resp) begin
          if (rsp_ready[m_id]) begin
            job = 0; m_ptr = (m_id + 1) % N;
          end
        end else if (!job && |req_valid) begin
          job = 1; t_acc = cyc; t_resp = -1; m_id = g;
          m_blk = req_block[g*512 +: 512];
          grant_log.push_back(g);
        end
        prev_dv = core_digest_valid;
      end
    end
  end

  // ---------------- requester / responder driver ----------------
  int pend[N];
  int seq[N];
  bit [N-1:0] use_abc = '0;
  int bp = 0;
  logic [N-1:0] bp_mask = '1;

  int acc_log[$], acc_cyc[$], start_log[$];
  int r_id[$], r_cyc[$], f_cycq[$], r_vis[$];
  logic [255:0] r_dig[$];
  bit r_err[$];
  logic [N-1:0] r_vec[$];
  bit shown = 0;
  int vis = 0, unstable = 0, f_cyc = 0;
  logic [255:0] f_dig;
  bit f_err;
  logic [1:0] f_id;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pend[i] > 0);
      req_block[i*512 +: 512] = use_abc[i] ? ABC_BLK : mk_block(i, seq[i]);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); start_log.delete();
    r_id.delete(); r_cyc.delete(); f_cycq.delete(); r_vis.delete();
    r_dig.delete(); r_err.delete(); r_vec.delete(); grant_log.delete();
    shown = 0; vis = 0; unstable = 0;
  endtask

  task automatic step();
    logic [N-1:0] rr, rv;
    @(negedge clk);
    rr = req_ready; rv = rsp_valid;
    if (core_start) start_log.push_back(cyc);
    for (int i = 0; i < N; i++)
      if (rr[i]) begin acc_log.push_back(i); acc_cyc.push_back(cyc); end
    if (rv != '0) begin
      vis++;
      if (!shown) begin
        shown = 1; f_dig = rsp_digest; f_err = rsp_error; f_id = rsp_id; f_cyc = cyc;
      end else if (rsp_digest !== f_dig || rsp_error !== f_err || rsp_id !== f_id) begin
        unstable++;
      end
      if ((rv & rsp_ready) != '0) begin
        r_id.push_back(int'(rsp_id)); r_dig.push_back(rsp_digest); r_err.push_back(rsp_error);
        r_vec.push_back(rv); r_cyc.push_back(cyc); f_cycq.push_back(f_cyc); r_vis.push_back(vis);
        shown = 0; vis = 0;
      end
    end
    @(posedge clk); #2;
    for (int i = 0; i < N; i++)
      if (rr[i]) begin pend[i]--; seq[i]++; end
    drive_inputs();
    if (bp > 0 && rv != '0) bp--;
    rsp_ready = (bp > 0) ? bp_mask : '1;
  endtask

  task automatic wait_resp(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (r_id.size() < n && k < budget) begin step(); k++; end
    checks++;
    if (r_id.size() < n) begin
      errors++;
      $display("FAIL %s_wait: got %0d responses expected %0d within %0d cycles", nm, r_id.size(), n, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; seq[i] = 0; end
    use_abc = '0; bp = 0; bp_mask = '1; rsp_ready = '1;
    drive_inputs();
    repeat (3) step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int exp3[8];
    int k;
    exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < N; i++) begin pend[i] = 0; seq[i] = 0; end

    // Single request carrying the "abc" block
    do_reset();
    stub_mode = 0; stub_lat = 5;
    use_abc[1] = 1'b1; pend[1] = 1; drive_inputs();
    wait_resp(1, 200, "t1");
    chk("t1_acc_count", acc_log.size(), 1);
    chk("t1_acc_id", acc_log[0], 1);
    chk("t1_start_lat", start_log[0] - acc_cyc[0], 1);
    chk("t1_rsp_vec", r_vec[0], 4'b0010);
    chk("t1_rsp_id", r_id[0], 1);
    chk("t1_digest", r_dig[0], ABC_DIG);
    chk("t1_error", r_err[0], 0);

    // Requesters 0 and 2 together from reset
    do_reset();
    stub_mode = 0; stub_lat = 4;
    pend[0] = 1; pend[2] = 1; drive_inputs();
    wait_resp(2, 200, "t2");
    chk("t2_first", acc_log[0], 0);
    chk("t2_second", acc_log[1], 2);
    chk("t2_start2_after_hs", start_log[1] - r_cyc[0], 2);
    chk("t2_dig0", r_dig[0], ref_digest(mk_block(0, 0)));
    chk("t2_dig2", r_dig[1], ref_digest(mk_block(2, 0)));

    // All four requesting continuously
    do_reset();
    stub_mode = 0; stub_lat = 2;
    for (int i = 0; i < N; i++) pend[i] = 2;
    drive_inputs();
    wait_resp(8, 400, "t3");
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t3_order_%0d", j), r_id[j], exp3[j]);
      chk($sformatf("t3_model_order_%0d", j), grant_log[j], exp3[j]);
    end

    // Core never completes -> watchdog response, then normal service
    do_reset();
    stub_mode = 2;
    pend[1] = 1; drive_inputs();
    wait_resp(1, 200, "t4");
    chk("t4_error", r_err[0], 1);
    chk("t4_digest", r_dig[0], '0);
    chk("t4_latency", f_cycq[0] - (start_log[0] + 1), 16);
    stub_mode = 0; stub_lat = 3;
    pend[2] = 1; drive_inputs();
    wait_resp(2, 200, "t4b");
    chk("t4b_error", r_err[1], 0);
    chk("t4b_digest", r_dig[1], ref_digest(mk_block(2, 0)));

    // Level-held digest_valid plus 10 cycles of response backpressure
    do_reset();
    stub_mode = 1; stub_lat = 3;
    bp = 10; bp_mask = 4'b1011; rsp_ready = bp_mask;
    pend[2] = 1; drive_inputs();
    wait_resp(1, 200, "t5");
    chk("t5_visible_cycles", r_vis[0], 11);
    chk("t5_stable", unstable, 0);
    chk("t5_lat_a", f_cycq[0] - start_log[0], 5);
    chk("t5_dig_a", r_dig[0], ref_digest(mk_block(2, 0)));
    pend[0] = 1; drive_inputs();
    wait_resp(2, 200, "t5b");
    chk("t5_lat_b", f_cycq[1] - start_log[1], 6);
    chk("t5_dig_b", r_dig[1], ref_digest(mk_block(0, 0)));

    // Asynchronous reset during WAIT
    do_reset();
    stub_mode = 2;
    pend[1] = 1; drive_inputs();
    k = 0;
    while (start_log.size() == 0 && k < 20) begin step(); k++; end
    repeat (3) step();
    chk("t6_pre_block", core_block, mk_block(1, 0));
    @(posedge clk); #3;
    rst_n = 1'b0;
    pend[1] = 0; drive_inputs();
    #1;
    chk("t6_rst_ctl", {req_ready, rsp_valid, core_start, rsp_error, rsp_id}, '0);
    chk("t6_rst_block", core_block, '0);
    chk("t6_rst_digest", rsp_digest, '0);
    clear_logs();
    repeat (3) step();
    rst_n = 1'b1;
    chk("t6_no_rsp", r_id.size(), 0);
    stub_mode = 0; stub_lat = 3;
    pend[3] = 1; drive_inputs();
    wait_resp(1, 200, "t6");
    chk("t6_grant", acc_log[0], 3);
    chk("t6_rsp_id", r_id[0], 3);
    chk("t6_digest", r_dig[0], ref_digest(mk_block(3, 0)));

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
